exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, which sets the operand, target and flag-evaluation width.
REQ-002 SHALL have parameter MUL_BITS, default 2, which sets the multiplier bits retired per cycle; WIDTH % MUL_BITS == 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the unit accepts this cycle.
REQ-007 SHALL have port in_op, input, 4 bits: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 MOV, 7 MUL, 8 JCC, 9 JMP; 10-15 illegal.
REQ-008 SHALL have port in_cond, input, 4 bits: x86 condition code for JCC.
REQ-009 SHALL have ports in_a and in_b, input, WIDTH bits each: operands; for JCC/JMP, in_b is the next RIP.
REQ-010 SHALL have port in_target, input, WIDTH bits: the branch target.
REQ-011 SHALL have port out_valid, output, 1 bit: out_result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port out_result, output, 2*WIDTH bits: the result.
REQ-014 SHALL have port flags, output, 5 bits: {OF,SF,ZF,PF,CF}, MSB first.
REQ-015 SHALL have ports branch_valid and branch_taken, output, 1 bit each: branch resolution.
REQ-016 SHALL have port branch_rip, output, WIDTH bits: the resolved RIP.
REQ-017 SHALL have port illegal_op, output, 1 bit: an illegal opcode was accepted.
REQ-018 SHALL have port busy, output, 1 bit: a multiply is in progress.

Function
REQ-019 SHALL implement the FSM states IDLE, MUL.
REQ-020 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready); accept = in_valid && in_ready; in_valid while !in_ready is ignored.
REQ-021 SHALL, for ADD/SUB/AND/OR/XOR/MOV accepted at edge E, assert out_valid after E with out_result = zero-extended WIDTH-bit result; MOV yields in_b.
REQ-022 SHALL, for MUL, enter MUL with busy=1, retire MUL_BITS multiplier bits per cycle, and assert out_valid WIDTH/MUL_BITS cycles after acceptance with the full 2*WIDTH unsigned product; it then returns to IDLE.
REQ-023 SHALL hold out_valid and out_result stable until out_valid && out_ready; clear out_valid on that edge unless a new result is loaded on the same edge (back-to-back throughput of 1 per cycle).
REQ-024 SHALL update the flags register on the acceptance edge of ADD, SUB, AND, OR, XOR and CMP only; all other ops leave flags unchanged.
REQ-025 SHALL compute flags on WIDTH bits: ZF = result==0; SF = result[WIDTH-1]; PF = even parity of result[7:0].
REQ-026 SHALL compute CF/OF as: ADD CF = carry-out, OF = signed overflow; SUB/CMP result = a-b, CF = borrow (a<b unsigned), OF = signed overflow; logic ops CF = OF = 0.
REQ-027 SHALL make CMP produce no out_valid.
REQ-028 SHALL resolve JCC against the flags register value at acceptance, so CMP followed immediately by JCC sees the CMP flags; cond 0-F follow x86: O, NO, B, AE, E, NE, BE, A, S, NS, P, NP, L, GE, LE, G.
REQ-029 SHALL make JMP always taken.
REQ-030 SHALL, for JCC/JMP, pulse branch_valid for exactly one cycle after acceptance with branch_rip = taken ? in_target : in_b; branches produce no out_valid.
REQ-031 SHALL treat an illegal opcode as a NOP: pulse illegal_op one cycle after acceptance, with no result and no flag change.
REQ-032 SHALL hold branch_valid, branch_taken and illegal_op at 0 in all cycles other than those pulses.

Reset
REQ-033 SHALL, on reset high at an edge, force state IDLE, clear the multiply counter, and clear all outputs and the flags register (out_result=0, flags=0, out_valid=0, branch_*=0, illegal_op=0, busy=0).
REQ-034 SHALL, if reset is asserted during MUL, abort the multiply with no out_valid ever produced for it.
REQ-035 SHALL hold in_ready=0 while reset is high, and in_ready=1 on the first cycle after reset deasserts.

Verification
REQ-036 SHALL be covered by the scenario: WIDTH=64, ADD a=FFFF_FFFF_FFFF_FFFF b=1 with out_ready=1 -> next cycle out_result=0, flags CF=1 ZF=1 OF=0 SF=0 PF=1.
REQ-037 SHALL be covered by the scenario: SUB a=8000_0000_0000_0000 b=1 -> out_result=7FFF_FFFF_FFFF_FFFF, OF=1, CF=0, SF=0.
REQ-038 SHALL be covered by the scenario: MUL a=b=FFFF_FFFF_FFFF_FFFF, MUL_BITS=2 -> busy for 32 cycles, in_ready=0, then out_valid with out_result=FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-039 SHALL be covered by the scenario: CMP 5,5 then JCC cond=4 (E), in_target=1000, in_b=2000 on the next cycle -> branch_valid pulse, branch_taken=1, branch_rip=1000; then JCC cond=5 -> branch_taken=0, branch_rip=2000.
REQ-040 SHALL be covered by the scenario: out_ready=0 with a result held -> in_ready=0 and out_result stable for 10 cycles; out_ready=1 -> transfer, then in_ready=1.
REQ-041 SHALL be covered by the scenario: reset at MUL cycle 10 -> all outputs 0 the next cycle and no out_valid afterward; in_op=12 -> illegal_op one-cycle pulse, flags unchanged.

Source files
------------

// File: rtl/exec_unit.sv
// ============================================================================
//  Module   : exec_unit
//  Purpose  : Single-issue execution unit with ALU ops, flags, x86-style
//             conditional branches and a multi-cycle shift-add multiplier.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module exec_unit #(
    parameter int WIDTH    = 64,
    parameter int MUL_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [3:0]           in_cond,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [4:0]           flags,
    output logic                 branch_valid,
    output logic                 branch_taken,
    output logic [WIDTH-1:0]     branch_rip,
    output logic                 illegal_op,
    output logic                 busy
);

    localparam int c_STEPS = WIDTH / MUL_BITS;
    localparam int c_CW    = $clog2(c_STEPS + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_STEPS - 1);

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_CMP = 4'd5;
    localparam logic [3:0] c_OP_MOV = 4'd6;
    localparam logic [3:0] c_OP_MUL = 4'd7;
    localparam logic [3:0] c_OP_JCC = 4'd8;
    localparam logic [3:0] c_OP_JMP = 4'd9;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]    r_acc;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mplier;

    logic                  w_accept;
    logic [WIDTH:0]        w_sum;
    logic [WIDTH:0]        w_diff;
    logic [WIDTH-1:0]      w_alu_res;
    logic                  w_cf;
    logic                  w_of;
    logic [4:0]            w_flags_new;
    logic                  w_sets_flags;
    logic                  w_has_result;
    logic                  w_is_branch;
    logic                  w_is_illegal;
    logic                  w_cond_base;
    logic                  w_taken;
    logic [2*WIDTH-1:0]    w_partial;
    logic [2*WIDTH-1:0]    w_acc_next;

    assign in_ready = !reset && (r_state == S_IDLE) && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state == S_MUL);

    assign w_sum  = {1'b0, in_a} + {1'b0, in_b};
    assign w_diff = {1'b0, in_a} - {1'b0, in_b};

    always_comb begin
        w_alu_res = '0;
        w_cf      = 1'b0;
        w_of      = 1'b0;
        case (in_op)
            c_OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_cf      = w_sum[WIDTH];
                w_of      = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            c_OP_SUB, c_OP_CMP: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_cf      = w_diff[WIDTH];
                w_of      = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            c_OP_AND: w_alu_res = in_a & in_b;
            c_OP_OR:  w_alu_res = in_a | in_b;
            c_OP_XOR: w_alu_res = in_a ^ in_b;
            c_OP_MOV: w_alu_res = in_b;
            default:  w_alu_res = '0;
        endcase
    end

    assign w_flags_new  = {w_of, w_alu_res[WIDTH-1], (w_alu_res == '0), ~^w_alu_res[7:0], w_cf};
    assign w_sets_flags = (in_op <= c_OP_CMP);
    assign w_has_result = (in_op <= c_OP_XOR) || (in_op == c_OP_MOV);
    assign w_is_branch  = (in_op == c_OP_JCC) || (in_op == c_OP_JMP);
    assign w_is_illegal = (in_op > c_OP_JMP);

    // Condition codes pair up: odd codes are the negation of the even code below them.
    always_comb begin
        w_cond_base = 1'b0;
        case (in_cond[3:1])
            3'd0: w_cond_base = flags[4];
            3'd1: w_cond_base = flags[0];
            3'd2: w_cond_base = flags[2];
            3'd3: w_cond_base = flags[0] | flags[2];
            3'd4: w_cond_base = flags[3];
            3'd5: w_cond_base = flags[1];
            3'd6: w_cond_base = flags[3] ^ flags[4];
            3'd7: w_cond_base = flags[2] | (flags[3] ^ flags[4]);
            default: w_cond_base = 1'b0;
        endcase
    end

    assign w_taken = (in_op == c_OP_JMP) || (w_cond_base ^ in_cond[0]);

    // Radix-2^MUL_BITS shift-add: multiplicand shifts left as multiplier digits retire.
    assign w_partial  = r_mcand * {{(2*WIDTH-MUL_BITS){1'b0}}, r_mplier[MUL_BITS-1:0]};
    assign w_acc_next = r_acc + w_partial;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && (in_op == c_OP_MUL)) w_state_next = S_MUL;
            S_MUL:  if (r_cnt == '0) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            flags        <= '0;
            branch_valid <= 1'b0;
            branch_taken <= 1'b0;
            branch_rip   <= '0;
            illegal_op   <= 1'b0;
        end else begin
            branch_valid <= 1'b0;
            branch_taken <= 1'b0;
            illegal_op   <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (r_state == S_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << MUL_BITS;
                r_mplier <= r_mplier >> MUL_BITS;
                if (r_cnt == '0) begin
                    out_valid  <= 1'b1;
                    out_result <= w_acc_next;
                end else begin
                    r_cnt <= r_cnt - c_CW'(1);
                end
            end

            if (w_accept) begin
                if (w_sets_flags) flags <= w_flags_new;
                if (w_has_result) begin
                    out_valid  <= 1'b1;
                    out_result <= {{WIDTH{1'b0}}, w_alu_res};
                end
                if (in_op == c_OP_MUL) begin
                    r_acc    <= '0;
                    r_mcand  <= {{WIDTH{1'b0}}, in_a};
                    r_mplier <= in_b;
                    r_cnt    <= c_CNT_LAST;
                end
                if (w_is_branch) begin
                    branch_valid <= 1'b1;
                    branch_taken <= w_taken;
                    branch_rip   <= w_taken ? in_target : in_b;
                end
                if (w_is_illegal) illegal_op <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ============================================================================
//  Module   : tb_exec_unit
//  Purpose  : Scoreboard bench for exec_unit using hand-computed vectors.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exec_unit;

    localparam int W  = 64;
    localparam int MB = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [3:0]      in_cond;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [W-1:0]    in_target;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_result;
    logic [4:0]      flags;
    logic            branch_valid;
    logic            branch_taken;
    logic [W-1:0]    branch_rip;
    logic            illegal_op;
    logic            busy;

    always #5 clk = ~clk;

    exec_unit #(.WIDTH(W), .MUL_BITS(MB)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_cond(in_cond),
        .in_a(in_a), .in_b(in_b), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .flags(flags), .branch_valid(branch_valid), .branch_taken(branch_taken),
        .branch_rip(branch_rip), .illegal_op(illegal_op), .busy(busy)
    );

    typedef struct packed { logic [2*W-1:0] res; logic [4:0] fl; } res_exp_t;
    typedef struct packed { logic taken; logic [W-1:0] rip; } br_exp_t;

    res_exp_t res_q[$];
    br_exp_t  br_q[$];
    res_exp_t mon_r;
    br_exp_t  mon_b;
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT hands over a result or branch.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (res_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result: got %h want no result", out_result);
                end else begin
                    mon_r = res_q.pop_front();
                    check("result", out_result, mon_r.res);
                    check("result_flags", {123'b0, flags}, {123'b0, mon_r.fl});
                end
            end
            if (branch_valid) begin
                if (br_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_branch: got rip %h want no branch", branch_rip);
                end else begin
                    mon_b = br_q.pop_front();
                    check("branch_taken", {127'b0, branch_taken}, {127'b0, mon_b.taken});
                    check("branch_rip", {64'b0, branch_rip}, {64'b0, mon_b.rip});
                end
            end else if (branch_taken) begin
                total++; bad++;
                $display("FAIL taken_without_valid: got 1 want 0");
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [3:0] cond,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] tgt,
                         input logic [2*W-1:0] exp_res, input logic [4:0] exp_fl,
                         input logic exp_taken, input logic [W-1:0] exp_rip, input bit push);
        int n;
        n = 0;
        in_valid = 1'b1; in_op = op; in_cond = cond; in_a = a; in_b = b; in_target = tgt;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end else if (push) begin
            if (op <= 4'd4 || op == 4'd6 || op == 4'd7) res_q.push_back('{exp_res, exp_fl});
            if (op == 4'd8 || op == 4'd9) br_q.push_back('{exp_taken, exp_rip});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (op == 4'd5) check("cmp_flags", {123'b0, flags}, {123'b0, exp_fl});
    endtask

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] T1   = 64'h1000;
    localparam logic [W-1:0] B2   = 64'h2000;

    int n;
    time t0;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_cond = '0; in_a = '0; in_b = '0; in_target = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {127'b0, in_ready}, 128'd0);
        check("reset_outputs", {out_result, flags, out_valid, busy, branch_valid, illegal_op},
              {128'd0, 5'd0, 4'd0});
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", {127'b0, in_ready}, 128'd1);
        @(posedge clk); #1;

        // ALU vectors: {OF,SF,ZF,PF,CF}
        issue(4'd0, 4'd0, ONES, 64'd1, '0, 128'd0, 5'b00111, 1'b0, '0, 1'b1);
        issue(4'd1, 4'd0, MSB, 64'd1, '0, {64'd0, 64'h7FFF_FFFF_FFFF_FFFF}, 5'b10010, 1'b0, '0, 1'b1);
        issue(4'd2, 4'd0, 64'hF0F0, 64'h0FF0, '0, 128'h00F0, 5'b00010, 1'b0, '0, 1'b1);
        issue(4'd3, 4'd0, MSB, 64'd1, '0, {64'd0, 64'h8000_0000_0000_0001}, 5'b01000, 1'b0, '0, 1'b1);
        issue(4'd4, 4'd0, 64'h55, 64'h55, '0, 128'd0, 5'b00110, 1'b0, '0, 1'b1);
        issue(4'd6, 4'd0, 64'd9, 64'h1234, '0, 128'h1234, 5'b00110, 1'b0, '0, 1'b1);
        issue(4'd0, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, '0, {64'd0, MSB}, 5'b11010, 1'b0, '0, 1'b1);
        issue(4'd7, 4'd0, 64'd3, 64'd5, '0, 128'd15, 5'b11010, 1'b0, '0, 1'b1);

        issue(4'd7, 4'd0, ONES, ONES, '0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001,
              5'b11010, 1'b0, '0, 1'b1);
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            if (in_ready) begin
                total++; bad++;
                $display("FAIL ready_during_mul: got 1 want 0");
            end
            n++;
            @(negedge clk);
        end
        check("mul_busy_cycles", 128'(n), 128'd32);
        check("mul_out_valid", {127'b0, out_valid}, 128'd1);
        @(posedge clk); #1;

        // Branches
        issue(4'd5, 4'd0, 64'd5, 64'd5, '0, '0, 5'b00110, 1'b0, '0, 1'b1);
        issue(4'd8, 4'd4, '0, B2, T1, '0, '0, 1'b1, T1, 1'b1);
        issue(4'd8, 4'd5, '0, B2, T1, '0, '0, 1'b0, B2, 1'b1);
        issue(4'd5, 4'd0, 64'd3, 64'd5, '0, '0, 5'b01001, 1'b0, '0, 1'b1);
        issue(4'd8, 4'hC, '0, B2, T1, '0, '0, 1'b1, T1, 1'b1);
        issue(4'd8, 4'd7, '0, B2, T1, '0, '0, 1'b0, B2, 1'b1);
        issue(4'd8, 4'd2, '0, B2, T1, '0, '0, 1'b1, T1, 1'b1);
        issue(4'd9, 4'd1, '0, B2, T1, '0, '0, 1'b1, T1, 1'b1);

        // Backpressure hold
        out_ready = 1'b0;
        issue(4'd0, 4'd0, 64'd1, 64'd2, '0, 128'd3, 5'b00010, 1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_state", {out_result, out_valid, in_ready}, {128'd3, 2'b10});
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {127'b0, in_ready}, 128'd1);
        @(posedge clk); #1;

        // Back-to-back throughput
        issue(4'd0, 4'd0, 64'd1, 64'd1, '0, 128'd2, 5'b00000, 1'b0, '0, 1'b1);
        t0 = $time;
        issue(4'd0, 4'd0, 64'd2, 64'd2, '0, 128'd4, 5'b00000, 1'b0, '0, 1'b1);
        check("back_to_back_gap", 128'($time - t0), 128'd10);

        // Reset during multiply
        issue(4'd7, 4'd0, ONES, ONES, '0, '0, '0, 1'b0, '0, 1'b0);
        repeat (9) @(posedge clk);
        #1; reset = 1'b1;
        @(negedge clk);
        check("reset_high_in_ready", {127'b0, in_ready}, 128'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_outputs", {out_result, flags, out_valid, busy, branch_valid, branch_taken, illegal_op},
              {128'd0, 5'd0, 5'd0});
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", {127'b0, in_ready}, 128'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("abort_no_result", 128'(n), 128'd0);
        @(posedge clk); #1;

        // Illegal opcode
        issue(4'd5, 4'd0, 64'd3, 64'd5, '0, '0, 5'b01001, 1'b0, '0, 1'b1);
        issue(4'd12, 4'd0, 64'd7, 64'd7, '0, '0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("illegal_pulse", {122'b0, illegal_op, flags}, {122'b0, 1'b1, 5'b01001});
        @(negedge clk);
        check("illegal_clear", {122'b0, illegal_op, flags}, {122'b0, 1'b0, 5'b01001});

        repeat (5) @(negedge clk);
        check("res_q_drained", 128'(res_q.size()), 128'd0);
        check("br_q_drained", 128'(br_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
